// File: rtl/display_count_gen_pkg.sv
// Shared widths and next-count helpers for the two-digit display counter.
// Step functions return {wrap, next} so callers get both from one call.
package display_pkg;

  localparam int COUNT_W  = 8;
  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] BCD_MAX_DIGIT = 4'd9;

  function automatic logic [COUNT_W:0] hex_step(input logic [COUNT_W-1:0] v, input logic up);
    logic [COUNT_W:0] r;
    if (up) r = {v == 8'hFF, v + 8'd1};
    else    r = {v == 8'h00, v - 8'd1};
    return r;
  endfunction

  function automatic logic [COUNT_W:0] bcd_step(input logic [COUNT_W-1:0] v, input logic up);
    logic [NIBBLE_W-1:0] lo;
    logic [NIBBLE_W-1:0] hi;
    logic                w;
    lo = v[NIBBLE_W-1:0];
    hi = v[COUNT_W-1:NIBBLE_W];
    w  = 1'b0;
    if (up) begin
      if (lo >= BCD_MAX_DIGIT) begin
        lo = '0;
        if (hi >= BCD_MAX_DIGIT) begin
          hi = '0;
          w  = 1'b1;
        end else begin
          hi = hi + 4'd1;
        end
      end else begin
        lo = lo + 4'd1;
      end
    end else begin
      if (lo == '0) begin
        lo = BCD_MAX_DIGIT;
        if (hi == '0) begin
          hi = BCD_MAX_DIGIT;
          w  = 1'b1;
        end else begin
          hi = hi - 4'd1;
        end
      end else begin
        lo = lo - 4'd1;
      end
    end
    return {w, hi, lo};
  endfunction

  // Loaded values are clamped digit-by-digit so only 0..9 ever reach the display.
  function automatic logic [COUNT_W-1:0] bcd_sat(input logic [COUNT_W-1:0] v);
    logic [NIBBLE_W-1:0] lo;
    logic [NIBBLE_W-1:0] hi;
    lo = v[NIBBLE_W-1:0];
    hi = v[COUNT_W-1:NIBBLE_W];
    if (lo > BCD_MAX_DIGIT) lo = BCD_MAX_DIGIT;
    if (hi > BCD_MAX_DIGIT) hi = BCD_MAX_DIGIT;
    return {hi, lo};
  endfunction

endpackage

// File: rtl/display_count_gen_if.sv
// Control and display-count bundle between the switch/key front end and the counter.
interface display_count_gen_if;
  import display_pkg::*;

  logic               en;
  logic               up_dn;
  logic               clear;
  logic               load;
  logic [COUNT_W-1:0] load_val;
  logic [COUNT_W-1:0] count;
  logic               tick;
  logic               wrap;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  count, tick, wrap
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output count, tick, wrap
  );
endinterface

// File: rtl/display_count_gen_tick_prescaler.sv
// Divides clk by CLK_HZ/TICK_HZ; tick_o is combinational and marks the last
// enabled cycle of each interval so the caller's registers update on the next edge.
module tick_prescaler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [W-1:0] presc;

  assign tick_o = en & (presc == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == LAST) ? '0 : presc + W'(1);
    end
  end

endmodule

// File: rtl/display_count_gen.sv
// Stepping two-digit display count (hex or BCD) feeding the HEX1/HEX0 decoders.
// Per-cycle priority is clear, then load, then a prescaler step.
module display_count_gen
  import display_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter bit BCD_MODE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  display_count_gen_if.slave  bus
);

  logic               step_now;
  logic [COUNT_W:0]   nxt;
  logic [COUNT_W-1:0] load_fix;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .clr   (bus.clear),
    .tick_o(step_now)
  );

  assign nxt      = BCD_MODE ? bcd_step(bus.count, bus.up_dn) : hex_step(bus.count, bus.up_dn);
  assign load_fix = BCD_MODE ? bcd_sat(bus.load_val) : bus.load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.count <= '0;
      bus.tick  <= 1'b0;
      bus.wrap  <= 1'b0;
    end else if (bus.clear) begin
      bus.count <= '0;
      bus.tick  <= 1'b0;
      bus.wrap  <= 1'b0;
    end else if (bus.load) begin
      bus.count <= load_fix;
      bus.tick  <= 1'b0;
      bus.wrap  <= 1'b0;
    end else if (step_now) begin
      bus.count <= nxt[COUNT_W-1:0];
      bus.tick  <= 1'b1;
      bus.wrap  <= nxt[COUNT_W];
    end else begin
      bus.tick  <= 1'b0;
      bus.wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_count_gen.sv
// Hex and BCD instances driven in lockstep and compared every cycle against a
// decimal/modular-arithmetic model of the display counter.
module tb_display_count_gen;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  display_count_gen_if hex_if ();
  display_count_gen_if bcd_if ();

  display_count_gen #(.CLK_HZ(DIV), .TICK_HZ(1), .BCD_MODE(1'b0)) u_hex (
    .clk(clk), .rst(rst), .bus(hex_if)
  );
  display_count_gen #(.CLK_HZ(DIV), .TICK_HZ(1), .BCD_MODE(1'b1)) u_bcd (
    .clk(clk), .rst(rst), .bus(bcd_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int m_cnt[2];
  bit m_tick[2];
  bit m_wrap[2];
  int m_phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int ref_next(input int c, input bit up, input bit bcd, output bit w);
    int d;
    if (!bcd) begin
      w = up ? (c == 255) : (c == 0);
      return (c + (up ? 1 : 255)) % 256;
    end
    d = (c / 16) * 10 + (c % 16);
    w = up ? (d == 99) : (d == 0);
    d = (d + (up ? 1 : 99)) % 100;
    return (d / 10) * 16 + (d % 10);
  endfunction

  function automatic int ref_load(input int lv, input bit bcd);
    int hi, lo;
    if (!bcd) return lv;
    hi = (lv / 16 > 9) ? 9 : lv / 16;
    lo = (lv % 16 > 9) ? 9 : lv % 16;
    return hi * 16 + lo;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_tick[k] = 1'b0;
      m_wrap[k] = 1'b0;
    end
    m_phase = 0;
  endtask

  task automatic check_all();
    chk("hex_count", hex_if.count, m_cnt[0]);
    chk("hex_tick",  hex_if.tick,  m_tick[0]);
    chk("hex_wrap",  hex_if.wrap,  m_wrap[0]);
    chk("bcd_count", bcd_if.count, m_cnt[1]);
    chk("bcd_tick",  bcd_if.tick,  m_tick[1]);
    chk("bcd_wrap",  bcd_if.wrap,  m_wrap[1]);
  endtask

  // Called at a falling edge: drive inputs, advance the model, check after the next rising edge.
  task automatic cycle(input bit e, input bit u, input bit c, input bit l, input logic [7:0] lv);
    bit step;
    bit w;
    hex_if.en = e; hex_if.up_dn = u; hex_if.clear = c; hex_if.load = l; hex_if.load_val = lv;
    bcd_if.en = e; bcd_if.up_dn = u; bcd_if.clear = c; bcd_if.load = l; bcd_if.load_val = lv;
    step = e && (m_phase == DIV - 1);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        m_cnt[k] = 0; m_tick[k] = 1'b0; m_wrap[k] = 1'b0;
      end else if (l) begin
        m_cnt[k] = ref_load(int'(lv), k == 1); m_tick[k] = 1'b0; m_wrap[k] = 1'b0;
      end else if (step) begin
        m_cnt[k] = ref_next(m_cnt[k], u, k == 1, w); m_tick[k] = 1'b1; m_wrap[k] = w;
      end else begin
        m_tick[k] = 1'b0; m_wrap[k] = 1'b0;
      end
    end
    if (c) m_phase = 0;
    else if (e) m_phase = (m_phase + 1) % DIV;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n, input bit e, input bit u);
    for (int i = 0; i < n; i++) cycle(e, u, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bit e, u, c, l;
    cycle_init: begin
      hex_if.en = 1'b0; hex_if.up_dn = 1'b1; hex_if.clear = 1'b0; hex_if.load = 1'b0; hex_if.load_val = '0;
      bcd_if.en = 1'b0; bcd_if.up_dn = 1'b1; bcd_if.clear = 1'b0; bcd_if.load = 1'b0; bcd_if.load_val = '0;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_hex_count", hex_if.count, 0);
    chk("rst_hex_tick",  hex_if.tick,  0);
    chk("rst_bcd_count", bcd_if.count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Basic up count from reset, then hex wrap up and down.
    run(25, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hFE);
    run(25, 1'b1, 1'b1);
    run(12, 1'b1, 1'b0);

    // BCD carry, wrap, borrow and saturated load.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h09);
    run(12, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h99);
    run(12, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    run(12, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hAF);
    run(3, 1'b1, 1'b1);

    // Load on the step cycle discards the step.
    for (int i = 0; i < DIV + 2 && m_phase != DIV - 1; i++) run(1, 1'b1, 1'b1);
    chk("phase_reached", m_phase, DIV - 1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h42);
    run(12, 1'b1, 1'b1);

    // Clear beats load and restarts the interval.
    run(4, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    run(12, 1'b1, 1'b1);

    // Pause mid-interval.
    run(4, 1'b1, 1'b1);
    run(25, 1'b0, 1'b1);
    run(15, 1'b1, 1'b1);

    // Asynchronous reset while count=37 and tick is high.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h36);
    for (int i = 0; i < 2 * DIV && !m_tick[0]; i++) run(1, 1'b1, 1'b1);
    chk("pre_rst_count", hex_if.count, 8'h37);
    chk("pre_rst_tick",  hex_if.tick,  1);
    #2 rst = 1'b1;
    #1;
    chk("async_hex_count", hex_if.count, 0);
    chk("async_hex_tick",  hex_if.tick,  0);
    chk("async_bcd_count", bcd_if.count, 0);
    chk("async_bcd_tick",  bcd_if.tick,  0);
    @(posedge clk);
    #1;
    chk("held_hex_count", hex_if.count, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(12, 1'b1, 1'b1);

    // Randomized traffic.
    u = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) u = ~u;
      c = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 29) == 0);
      cycle(e, u, c, l, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/display_count_gen.md
Name: display_count_gen

Overview:
- Upstream feeder for the two-digit seven-segment hex display stage.
- Divides the 50 MHz board clock into a slow step tick.
- Maintains an 8-bit display count (hex or two-digit BCD) that steps on each tick. The two nibbles drive HEX0 (low) and HEX1 (high) through the existing decoder.
- Supports clear, parallel load, enable and up/down control from switches and keys.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
TICK_HZ, 1, step rate in Hz; DIV = CLK_HZ/TICK_HZ, must be >= 2 (elaboration error otherwise)
BCD_MODE, 0, 0 = 8-bit binary 00..FF; 1 = two BCD digits 00..99

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous active-high reset
en  input  1  1 = prescaler runs and count steps on tick; 0 = both hold
up_dn  input  1  1 = count up, 0 = count down (sampled on tick cycle)
clear  input  1  synchronous clear of count and prescaler
load  input  1  synchronous parallel load of count
load_val  input  8  value loaded when load=1
count  output  8  registered display count; [3:0] → HEX0, [7:4] → HEX1
tick  output  1  registered one-cycle pulse marking a count step
wrap  output  1  registered one-cycle pulse, asserted with the count update that wraps

Behaviour:
- Reset (rst=1, asynchronous): count=8'h00, prescaler=0, tick=0, wrap=0. All state holds at these values until rst deasserts. Reset mid-step abandons the step.
- Prescaler:
  - Width is clog2(DIV). When en=1 it counts 0..DIV-1, then returns to 0.
  - Internal step_now = en & (presc == DIV-1).
  - en=0 freezes the prescaler value.
- Priority per cycle: clear > load > step.
  - clear=1: count←0, prescaler←0, tick←0, wrap←0.
  - load=1 (clear=0): count←load_val (BCD_MODE=1: any nibble >9 is saturated to 9). Prescaler is unaffected. tick←0, wrap←0. Any coincident step is discarded.
  - step_now=1 (no clear/load): count←next(count, up_dn), tick←1. wrap←1 iff a wrap occurred.
  - Otherwise: count holds, tick←0, wrap←0.
- next() in binary mode: modulo-256. Up FF→00 wraps; down 00→FF wraps.
- next() in BCD mode:
  - Low digit 9→0 carries into the high digit; 0→9 borrows.
  - Up 99→00 wraps; down 00→99 wraps.
  - Only digits 0..9 ever appear.
- Latency: count, tick and wrap change on the clock edge following the cycle in which step_now is high. From en rising with prescaler at 0, the first tick occurs DIV cycles later. Steady state is one tick every DIV cycles.
- tick is never high on two consecutive cycles (DIV>=2).
- up_dn changing between ticks has no effect until the next step.

Decomposition:
- Package display_pkg:
  - COUNT_W=8 and NIBBLE_W=4.
  - BCD_MAX_DIGIT=4'd9.
  - Function bcd_step(logic [7:0] v, logic up) returning {wrap, next}.
  - Function hex_step with the same signature.
- Sub-module tick_prescaler (params CLK_HZ, TICK_HZ; ports clk, rst, en, clr, tick_o) produces step_now. display_count_gen instantiates it and holds the count/tick/wrap registers.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10) unless noted.
- Reset/basic count: rst pulse, en=1, up_dn=1, BCD_MODE=0 → count=00 after reset; count=01 ten cycles after en, 02 twenty cycles after; tick high exactly one cycle per step.
- Hex wrap: load_val=8'hFE, load one cycle, then run up → FF, then 00 with wrap=1 on that update only. Then up_dn=0 from 00 → FF with wrap=1.
- BCD mode: BCD_MODE=1, load 8'h09, up → 10 (not 0A); load 8'h99, up → 00 with wrap=1; load 8'h00, down → 99 with wrap=1; load 8'hAF → count=99.
- Priority/simultaneity:
  - load=1 on the step_now cycle → count=load_val, tick=0.
  - clear=1 with load=1 → count=00, and the next tick arrives 10 cycles after clear releases.
  - en=0 for 25 cycles mid-interval → no ticks; the interval resumes where it stopped.
- Async reset mid-operation: assert rst between clock edges with count=8'h37 → count=00, tick=0 immediately without a clock edge; after release, the first step arrives 10 cycles after the first enabled edge.
- Default parameters (50 MHz / 1 Hz): with en=1, tick period is exactly 50_000_000 cycles, checked over 3 periods.
